fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter ALIGN_CHK, default 1: when 1, redirect targets with bits [1:0] nonzero raise an error; when 0, bits [1:0] are forced to 0.
REQ-003 Port clk_i  in  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_i  in  1: reset, asynchronous assert, active-low.
REQ-005 Port redir_i  in  1: redirect request (branch/jal/jalr taken) from execute.
REQ-006 Port redir_pc_i  in  32: redirect target, valid when redir_i=1.
REQ-007 Port imem_req_o  out  1: instruction memory request.
REQ-008 Port imem_addr_o  out  32: byte address of request, word aligned.
REQ-009 Port imem_gnt_i  in  1: memory accepted request this cycle.
REQ-010 Port imem_rvalid_i  in  1: read data valid; one per granted request, at least 1 cycle after grant.
REQ-011 Port imem_rdata_i  in  32: instruction word.
REQ-012 Port inst_valid_o  out  1: instruction offered to decode.
REQ-013 Port inst_ready_i  in  1: decode accepts; transfer when valid and ready are both 1.
REQ-014 Port inst_o / pc_o / pc4_o  out  32 each: held instruction, its PC, PC+4.
REQ-015 Port fetch_err_o  out  1: misaligned redirect target pending.

Function
REQ-016 FSM states SHALL be FETCH, WAIT, OUT and ERR; at most one memory request is outstanding.
REQ-017 FETCH: imem_req_o=1 and imem_addr_o=fetch_pc; on gnt, go to WAIT.
REQ-018 WAIT: imem_req_o=0; on rvalid with kill=0, capture rdata/pc into the output buffer and go to OUT.
REQ-019 OUT: inst_valid_o=1, with outputs stable until the transfer; on transfer, set fetch_pc=pc+4 and go to FETCH.
REQ-020 Redirect SHALL take priority in every state; fetch_pc takes redir_pc_i on the same edge.
REQ-021 Redirect in FETCH without gnt: next cycle is FETCH at the new address. The address may change while it is not granted.
REQ-022 Redirect in FETCH with gnt, or in WAIT without rvalid: go to or stay in WAIT with kill=1. The next rvalid is discarded and clears kill, then go to FETCH.
REQ-023 Redirect in WAIT with rvalid on the same cycle: discard the data and go to FETCH.
REQ-024 Redirect in OUT without transfer: the held instruction is dropped, inst_valid_o=0 next cycle, and the FSM goes to FETCH.
REQ-025 Redirect in OUT together with a transfer: the transfer counts, and the next fetch_pc is redir_pc_i, not pc+4.
REQ-026 Misaligned redirect with ALIGN_CHK=1: go to ERR with fetch_err_o=1, no request, and inst_valid_o=0 until an aligned redirect, which goes to FETCH or to WAIT with kill=1 per REQ-022.
REQ-027 pc4_o SHALL equal pc_o+4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-028 Latency: grant on the first FETCH cycle and rvalid 1 cycle later give inst_valid_o 2 cycles after FETCH entry; peak throughput is 1 instruction per 3 cycles.
REQ-029 Outputs SHALL be registered, except imem_req_o and imem_addr_o, which decode the state and fetch_pc directly.

Reset
REQ-030 While rst_i=0: state=FETCH, fetch_pc=RESET_PC, kill=0, imem_req_o=0, inst_valid_o=0, inst_o=0, pc_o=RESET_PC, pc4_o=RESET_PC+4, fetch_err_o=0.
REQ-031 imem_req_o SHALL rise on the first cycle after rst_i deasserts.
REQ-032 Reset during WAIT SHALL abandon the request; the memory is reset by the same rst_i.

Structure
REQ-033 The shared defines header SHALL hold the FSM state encodings, the RESET_PC default and NOP (32'h0000_0013).
REQ-034 One sub-module, fetch_buf, SHALL be the one-entry inst/pc holding register with load and clear.
REQ-035 Target size is 150-300 lines of RTL.

Verification
REQ-036 Reset release, gnt same cycle, rvalid +1, ready=1: instructions fetched at 0x0, 0x4, 0x8 with pc4_o 0x4, 0x8, 0xC.
REQ-037 ready held 0 for 5 cycles in OUT: inst_o, pc_o and inst_valid_o stay stable, and no imem_req_o occurs.
REQ-038 Redirect to 0x100 in WAIT, rvalid 2 cycles later: that data is never presented, and the next request address is 0x100.
REQ-039 Redirect to 0x200 on the same cycle as a transfer of pc 0x10: the 0x10 instruction is consumed, and the next fetch is 0x200, not 0x14.
REQ-040 Redirect to 0x102 with ALIGN_CHK=1: fetch_err_o=1 with no requests; a following redirect to 0x104 clears the error and fetches 0x104.
REQ-041 rst_i pulsed low mid-WAIT: all outputs return to reset values asynchronously, and fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared definitions for the instruction fetch controller.
//   state_t          - fetch FSM state encodings
//   RESET_PC_DEFAULT - default first fetch address after reset
//   NOP              - canonical no-op instruction (addi x0, x0, 0)
//   misaligned()     - true when a byte address is not word aligned
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_OUT   = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction memory and decode handshake bundle.
//   master (fetch side): drives imem_req_o/imem_addr_o, inst_valid_o, inst_o,
//                        pc_o, pc4_o, fetch_err_o
//   slave  (env side)  : drives imem_gnt_i, imem_rvalid_i, imem_rdata_i,
//                        inst_ready_i
interface fetch_ctrl_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic        fetch_err_o;

    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o, pc4_o, fetch_err_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o, pc4_o, fetch_err_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i
    );
endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: one-entry holding register for the instruction offered to decode.
//   clk, rst_n    - clock, async active-low reset
//   load          - capture inst_d/pc_d and mark valid (wins over clr)
//   clr           - drop the held instruction
//   valid         - entry holds an instruction
//   inst, pc, pc4 - held instruction, its PC, and PC+4 (registered)
module fetch_buf
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clr,
    input  logic [31:0] inst_d,
    input  logic [31:0] pc_d,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            inst  <= '0;
            pc    <= RESET_PC;
            pc4   <= RESET_PC + 32'd4;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= inst_d;
            pc    <= pc_d;
            pc4   <= pc_d + 32'd4;   // wraps naturally at 2^32
        end else if (clr) begin
            // A dropped slot shows a harmless no-op to anyone peeking at inst.
            valid <= 1'b0;
            inst  <= NOP;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch controller.
//   clk_i, rst_i         - clock, async active-low reset
//   redir_i, redir_pc_i  - redirect request and target from execute
//   bus (master)         - imem request/grant/response and decode valid/ready,
//                          plus held inst/pc/pc4 and misaligned-target error
// Redirects win in every state. A request already granted when a redirect
// lands is tracked by kill so its response is thrown away.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter bit          ALIGN_CHK = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          redir_i,
    input  logic [31:0]   redir_pc_i,
    fetch_ctrl_if.master  bus
);

    state_t      state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        err_q;
    logic        outstanding;   // a granted request will still return data
    logic        buf_load, buf_clr, buf_valid, xfer, redir_bad;
    logic [31:0] redir_tgt;

    assign redir_bad = ALIGN_CHK && misaligned(redir_pc_i);
    assign redir_tgt = ALIGN_CHK ? redir_pc_i : {redir_pc_i[31:2], 2'b00};
    assign xfer      = buf_valid && bus.inst_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_FETCH;
            kill_q     <= 1'b0;
            fetch_pc_q <= RESET_PC;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            fetch_pc_q <= fetch_pc_d;
            err_q      <= (state_d == ST_ERR);
        end
    end

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        fetch_pc_d  = fetch_pc_q;
        buf_load    = 1'b0;
        buf_clr     = xfer;
        outstanding = 1'b0;

        case (state_q)
            ST_FETCH: begin
                outstanding = bus.imem_gnt_i;
                if (bus.imem_gnt_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                outstanding = !bus.imem_rvalid_i;
                if (bus.imem_rvalid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (xfer) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = ST_FETCH;
                end
            end
            ST_ERR: begin
                // A request granted before entering ERR may still be in flight.
                outstanding = kill_q && !bus.imem_rvalid_i;
                if (kill_q && bus.imem_rvalid_i) kill_d = 1'b0;
            end
            default: state_d = ST_FETCH;
        endcase

        if (redir_i) begin
            buf_load   = 1'b0;
            buf_clr    = 1'b1;
            fetch_pc_d = redir_tgt;
            kill_d     = outstanding;
            if (redir_bad)        state_d = ST_ERR;
            else if (outstanding) state_d = ST_WAIT;
            else                  state_d = ST_FETCH;
        end
    end

    fetch_buf #(.RESET_PC(RESET_PC)) u_buf (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .load   (buf_load),
        .clr    (buf_clr),
        .inst_d (bus.imem_rdata_i),
        .pc_d   (fetch_pc_q),
        .valid  (buf_valid),
        .inst   (bus.inst_o),
        .pc     (bus.pc_o),
        .pc4    (bus.pc4_o)
    );

    // Request is gated by reset so it is low while held and rises on release.
    assign bus.imem_req_o   = rst_i && (state_q == ST_FETCH);
    assign bus.imem_addr_o  = fetch_pc_q;
    assign bus.inst_valid_o = buf_valid;
    assign bus.fetch_err_o  = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] tgt;
        int          lat;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
    } vec_t;

    logic        clk, rst_n, redir;
    logic [31:0] redir_pc;
    fetch_ctrl_if bus();

    int   n_cmp = 0, n_err = 0;
    exp_t sb[$];
    int   gnt_en = 1, rv_lat = 1, req_cnt = 0;
    vec_t vecs[4];

    fetch_ctrl #(.RESET_PC(32'h0), .ALIGN_CHK(1'b1)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .redir_i    (redir),
        .redir_pc_i (redir_pc),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc = pc; e.pc4 = pc + 32'd4; e.inst = mem(pc);
        sb.push_back(e);
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 60 && !bus.inst_valid_o; i++) tick();
        chk(nm, {31'd0, bus.inst_valid_o}, 32'd1);
    endtask

    task automatic take();
        wait_valid("valid_wait");
        bus.inst_ready_i = 1'b1;
        tick();
        bus.inst_ready_i = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redir = 1'b1;
        redir_pc = tgt;
        tick();
        redir = 1'b0;
    endtask

    task automatic wait_grant(input logic [31:0] a);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #3;
            if (bus.imem_gnt_i && bus.imem_addr_o == a) found = 1;
        end
        chk("grant_seen", {31'd0, found}, 32'd1);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
        chk(nm, sb.size(), 32'd0);
    endtask

    // Memory model: grants every request, returns data rv_lat cycles later.
    initial begin
        bit          pend = 0;
        int          cnt = 0;
        logic [31:0] paddr = '0, gaddr = '0;
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) pend = 0;
            else begin
                if (bus.imem_rvalid_i) pend = 0;
                if (bus.imem_gnt_i) begin
                    pend = 1; cnt = rv_lat; paddr = gaddr;
                end
            end
            #2;
            bus.imem_rvalid_i = 1'b0;
            bus.imem_gnt_i = 1'b0;
            if (rst_n) begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.imem_rvalid_i = 1'b1;
                        bus.imem_rdata_i = mem(paddr);
                    end
                end
                bus.imem_gnt_i = bus.imem_req_o && (gnt_en != 0);
                if (bus.imem_gnt_i) gaddr = bus.imem_addr_o;
                if (bus.imem_req_o) req_cnt++;
            end
        end
    end

    // Scoreboard: every decode transfer must match the next expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.inst_valid_o && bus.inst_ready_i) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_pc", bus.pc_o, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", bus.pc_o, e.pc);
                    chk("sb_pc4", bus.pc4_o, e.pc4);
                    chk("sb_inst", bus.inst_o, e.inst);
                end
            end
        end
    end

    initial begin
        int r0;
        vecs[0] = '{32'h0000_0040, 1, 32'h0000_0040, 32'h0000_0044};
        vecs[1] = '{32'h0000_1000, 3, 32'h0000_1000, 32'h0000_1004};
        vecs[2] = '{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h7FFF_FFF8, 2, 32'h7FFF_FFF8, 32'h7FFF_FFFC};

        rst_n = 1'b0; redir = 1'b0; redir_pc = '0; bus.inst_ready_i = 1'b0;
        repeat (3) tick();
        chk("rst_req", {31'd0, bus.imem_req_o}, 32'd0);
        chk("rst_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        chk("rst_inst", bus.inst_o, 32'd0);
        chk("rst_pc", bus.pc_o, 32'd0);
        chk("rst_pc4", bus.pc4_o, 32'd4);
        chk("rst_err", {31'd0, bus.fetch_err_o}, 32'd0);

        // Sequential fetch from reset, 2-cycle latency to first valid.
        push(32'h0); push(32'h4); push(32'h8);
        bus.inst_ready_i = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("rel_req", {31'd0, bus.imem_req_o}, 32'd1);
        chk("rel_addr", bus.imem_addr_o, 32'h0);
        tick();
        chk("lat_valid_c1", {31'd0, bus.inst_valid_o}, 32'd0);
        tick();
        chk("lat_valid_c2", {31'd0, bus.inst_valid_o}, 32'd1);
        drain("seq_drain");
        bus.inst_ready_i = 1'b0;

        // Stall in OUT: outputs hold, no new requests.
        wait_valid("stall_valid");
        r0 = req_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, bus.inst_valid_o}, 32'd1);
            chk("stall_pc", bus.pc_o, 32'hC);
            chk("stall_inst", bus.inst_o, mem(32'hC));
            tick();
        end
        chk("stall_no_req", req_cnt, r0);
        push(32'hC);
        take();
        drain("stall_drain");

        // Table: redirect targets, varying memory latency, pc4 wrap.
        for (int v = 0; v < 4; v++) begin
            rv_lat = vecs[v].lat;
            redirect(vecs[v].tgt);
            begin
                exp_t e;
                e.pc = vecs[v].exp_pc; e.pc4 = vecs[v].exp_pc4; e.inst = mem(vecs[v].exp_pc);
                sb.push_back(e);
            end
            take();
            drain("vec_drain");
        end

        // Redirect while waiting: the in-flight data must be discarded.
        rv_lat = 3;
        redirect(32'h80);
        wait_grant(32'h80);
        tick();
        push(32'h100);
        redirect(32'h100);
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (bus.imem_req_o) seen = 1; else tick();
            end
            chk("kill_req_seen", {31'd0, seen}, 32'd1);
            chk("kill_next_addr", bus.imem_addr_o, 32'h100);
        end
        take();
        drain("kill_drain");

        // Redirect together with a transfer: transfer counts, next is target.
        rv_lat = 1;
        redirect(32'h10);
        wait_valid("xr_valid");
        push(32'h10); push(32'h200);
        bus.inst_ready_i = 1'b1; redir = 1'b1; redir_pc = 32'h200;
        tick();
        bus.inst_ready_i = 1'b0; redir = 1'b0;
        take();
        drain("xr_drain");

        // Misaligned target: error, no requests, until an aligned redirect.
        redirect(32'h102);
        r0 = req_cnt;
        for (int i = 0; i < 4; i++) begin
            chk("err_flag", {31'd0, bus.fetch_err_o}, 32'd1);
            chk("err_valid", {31'd0, bus.inst_valid_o}, 32'd0);
            tick();
        end
        chk("err_no_req", req_cnt, r0);
        push(32'h104);
        redirect(32'h104);
        chk("err_clear", {31'd0, bus.fetch_err_o}, 32'd0);
        take();
        drain("err_drain");

        // Asynchronous reset mid-WAIT, then restart at the reset PC.
        rv_lat = 4;
        redirect(32'h300);
        wait_grant(32'h300);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, bus.imem_req_o}, 32'd0);
        chk("arst_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        chk("arst_inst", bus.inst_o, 32'd0);
        chk("arst_pc", bus.pc_o, 32'd0);
        chk("arst_pc4", bus.pc4_o, 32'd4);
        chk("arst_err", {31'd0, bus.fetch_err_o}, 32'd0);
        tick(); tick();
        rv_lat = 1;
        push(32'h0);
        rst_n = 1'b1;
        #1;
        chk("rerel_req", {31'd0, bus.imem_req_o}, 32'd1);
        chk("rerel_addr", bus.imem_addr_o, 32'h0);
        take();
        drain("rerel_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
